// File: rtl/row_brightness_engine_if.sv
`default_nettype none
// ============================================================================
// Module  : row_brightness_engine_if
// Purpose : Read-port bundle between the instruction buffer and the row
//           brightness engine.
// Ports   : instr_replay  engine -> buffer, rewinds the buffer read pointer
//           instr_valid   buffer -> engine, instruction present
//           instr_ready   engine -> buffer, engine accepts instruction
//           instr_last    buffer -> engine, final instruction of the list
//           instr_data    buffer -> engine, {op[1:0], x0, y0, x1, y1}
// Modports: master = buffer side, slave = engine side
// Revision: 1.0  initial release
// ============================================================================
interface row_brightness_engine_if #(
    parameter int COORD_WIDTH = 10
);
    localparam int INSTRUCTION_WIDTH = 2 + 4 * COORD_WIDTH;

    logic                         instr_replay;
    logic                         instr_valid;
    logic                         instr_ready;
    logic                         instr_last;
    logic [INSTRUCTION_WIDTH-1:0] instr_data;

    modport master (
        input  instr_replay,
        input  instr_ready,
        output instr_valid,
        output instr_last,
        output instr_data
    );

    modport slave (
        output instr_replay,
        output instr_ready,
        input  instr_valid,
        input  instr_last,
        input  instr_data
    );
endinterface
`default_nettype wire

// File: rtl/row_brightness_engine.sv
`default_nettype none
// ============================================================================
// Module  : row_brightness_engine
// Purpose : Computes total grid brightness one row at a time. For every row
//           the buffered instruction list is replayed, matching spans are
//           swept into a GRID_SIZE-cell row RAM, and the RAM is then summed
//           into the running total and cleared.
// Ports   : clk, reset      clock, asynchronous active-high reset
//           instr (slave)   instruction buffer read port
//           result_valid    total is final (held until reset)
//           result          grid brightness total
// Config  : LIT_COUNT_MODE_EN - 1-bit cells (on/off/invert), SUM counts lit
//           cells; undefined = saturating brightness cells of CELL_WIDTH bits.
// Revision: 1.0  initial release
// ============================================================================
module row_brightness_engine #(
    parameter int COORD_WIDTH  = 10,
    parameter int GRID_SIZE    = 1000,
    parameter int CELL_WIDTH   = 16,
    parameter int RESULT_WIDTH = 32
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    row_brightness_engine_if.slave       instr,
    output logic                         result_valid,
    output logic [RESULT_WIDTH-1:0]      result
);
    localparam int INSTRUCTION_WIDTH = 2 + 4 * COORD_WIDTH;
    localparam int ADDR_W = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
`ifdef LIT_COUNT_MODE_EN
    localparam int CELL_W = 1;
`else
    localparam int CELL_W = CELL_WIDTH;
`endif
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(GRID_SIZE - 1);
    localparam logic [CELL_W-1:0] CELL_MAX  = '1;

    localparam logic [2:0] S_CLEAR  = 3'd0;
    localparam logic [2:0] S_REPLAY = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_SWEEP  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_SUM    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]              state, state_next;
    logic [ADDR_W-1:0]       addr, end_addr, pipe_addr, row;
    logic [1:0]              op_q;
    logic                    last_q, issue_done, pipe_valid;
    logic [RESULT_WIDTH-1:0] total;
    logic [CELL_W-1:0]       rd_data, cell_mod, ram_wdata;
    logic [ADDR_W-1:0]       ram_waddr;
    logic                    ram_we, issue, fire, hit, final_write;

    // Instruction fields, widened to 32 bits so all comparisons share a width.
    logic [1:0]  f_op;
    logic [31:0] f_x0, f_y0, f_x1, f_y1, f_x1_clamped, row_w;
    assign f_op = instr.instr_data[INSTRUCTION_WIDTH-1 -: 2];
    assign f_x0 = 32'(instr.instr_data[4*COORD_WIDTH-1 -: COORD_WIDTH]);
    assign f_y0 = 32'(instr.instr_data[3*COORD_WIDTH-1 -: COORD_WIDTH]);
    assign f_x1 = 32'(instr.instr_data[2*COORD_WIDTH-1 -: COORD_WIDTH]);
    assign f_y1 = 32'(instr.instr_data[COORD_WIDTH-1:0]);
    assign row_w = 32'(row);
    assign f_x1_clamped = (f_x1 < 32'(GRID_SIZE)) ? f_x1 : 32'(GRID_SIZE - 1);

    assign fire  = instr.instr_valid && instr.instr_ready;
    assign hit   = (f_y0 <= row_w) && (row_w <= f_y1) && (f_x0 <= f_x1) &&
                   (f_x0 < 32'(GRID_SIZE)) && (f_op != 2'b11);
    // SWEEP and SUM issue one read per cycle until end_addr has been issued;
    // the state ends when the write for end_addr retires.
    assign issue       = ((state == S_SWEEP) || (state == S_SUM)) && !issue_done;
    assign final_write = pipe_valid && (pipe_addr == end_addr);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_CLEAR;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR:  if (addr == LAST_CELL) state_next = S_REPLAY;
            S_REPLAY: state_next = S_FETCH;
            S_FETCH:  if (fire) state_next = hit ? S_SWEEP : S_NEXT;
            S_SWEEP:  if (final_write) state_next = S_NEXT;
            S_NEXT:   state_next = last_q ? S_SUM : S_FETCH;
            S_SUM:    if (final_write) state_next = (row == LAST_CELL) ? S_DONE : S_REPLAY;
            S_DONE:   state_next = S_DONE;
            default:  state_next = S_CLEAR;
        endcase
    end

    // Output logic
    always_comb begin
        instr.instr_ready  = (state == S_FETCH);
        instr.instr_replay = (state == S_REPLAY);
        result_valid       = (state == S_DONE);
        result             = (state == S_DONE) ? total : '0;
    end

    // Datapath: address sequencing, latched instruction, read pipeline, total
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            end_addr   <= '0;
            pipe_addr  <= '0;
            row        <= '0;
            op_q       <= 2'b00;
            last_q     <= 1'b0;
            issue_done <= 1'b0;
            pipe_valid <= 1'b0;
            total      <= '0;
        end else begin
            pipe_valid <= issue;
            pipe_addr  <= addr;
            case (state)
                S_CLEAR: addr <= (addr == LAST_CELL) ? '0 : addr + ADDR_W'(1);
                S_FETCH: begin
                    if (fire) begin
                        addr       <= ADDR_W'(f_x0);
                        end_addr   <= ADDR_W'(f_x1_clamped);
                        op_q       <= f_op;
                        last_q     <= instr.instr_last;
                        issue_done <= 1'b0;
                    end
                end
                S_SWEEP, S_SUM: begin
                    if (issue) begin
                        if (addr == end_addr) issue_done <= 1'b1;
                        else                  addr <= addr + ADDR_W'(1);
                    end
                    if ((state == S_SUM) && pipe_valid)
                        total <= total + RESULT_WIDTH'(rd_data);
                    if ((state == S_SUM) && final_write && (row != LAST_CELL))
                        row <= row + ADDR_W'(1);
                end
                S_NEXT: begin
                    // Preload a full-row scan in case this turns into SUM.
                    addr       <= '0;
                    end_addr   <= LAST_CELL;
                    issue_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Cell update applied to the value read one cycle earlier
    always_comb begin
        cell_mod = rd_data;
`ifdef LIT_COUNT_MODE_EN
        case (op_q)
            2'b00:   cell_mod = 1'b0;
            2'b01:   cell_mod = 1'b1;
            2'b10:   cell_mod = ~rd_data;
            default: cell_mod = rd_data;
        endcase
`else
        case (op_q)
            2'b00:   cell_mod = (rd_data == '0) ? '0 : rd_data - CELL_W'(1);
            2'b01:   cell_mod = (rd_data == CELL_MAX) ? CELL_MAX : rd_data + CELL_W'(1);
            2'b10:   cell_mod = (rd_data >= CELL_MAX - CELL_W'(1)) ? CELL_MAX
                                                                  : rd_data + CELL_W'(2);
            default: cell_mod = rd_data;
        endcase
`endif
    end

    // Single write port: CLEAR zeroes sequentially, SUM zeroes behind the
    // read, SWEEP writes the modified cell behind the read.
    always_comb begin
        ram_we    = (state == S_CLEAR) || pipe_valid;
        ram_waddr = (state == S_CLEAR) ? addr : pipe_addr;
        ram_wdata = (state == S_SWEEP) ? cell_mod : '0;
    end

    // Row RAM, no reset: CLEAR takes care of stale contents.
    logic [CELL_W-1:0] ram [GRID_SIZE];
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        rd_data <= ram[addr];
    end
endmodule
`default_nettype wire
